// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder slice and carry flop, LSB first.
// Define SERIAL_ADD_SUB_NEGATE_EN to report |A-B| for negative subtract results.
module serial_add_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CTR,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             sign,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
`ifdef SERIAL_ADD_SUB_NEGATE_EN
    , ST_NEG = 2'd3
`endif
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic [CW-1:0]    r_cnt;
  logic             r_ctr;
  logic             r_c;
  logic             r_cout;
  logic             r_sign;

  logic w_op_a;
  logic w_op_b;
  logic w_sum;
  logic w_carry;
  logic w_last;
  logic w_sign_calc;

  assign w_last      = (r_cnt == CW'(WIDTH - 1));
  assign w_sign_calc = r_ctr & ~w_carry;

  // The one slice is shared: CALC feeds operand bits, NEG feeds the inverted result bit.
  always_comb begin
    w_op_a = r_a[0];
    w_op_b = r_b[0] ^ r_ctr;
`ifdef SERIAL_ADD_SUB_NEGATE_EN
    if (r_state == ST_NEG) begin
      w_op_a = ~r_s[0];
      w_op_b = 1'b0;
    end
`endif
    w_sum   = w_op_a ^ w_op_b ^ r_c;
    w_carry = (w_op_a & w_op_b) | (w_op_a & r_c) | (w_op_b & r_c);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_CALC;
      ST_CALC: begin
        if (w_last) begin
`ifdef SERIAL_ADD_SUB_NEGATE_EN
          w_next = w_sign_calc ? ST_NEG : ST_DONE;
`else
          w_next = ST_DONE;
`endif
        end
      end
`ifdef SERIAL_ADD_SUB_NEGATE_EN
      ST_NEG:  if (w_last) w_next = ST_DONE;
`endif
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_cnt   <= '0;
      r_ctr   <= 1'b0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_sign  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a   <= A;
            r_b   <= B;
            r_ctr <= CTR;
            r_c   <= CTR;
            r_cnt <= '0;
          end
        end
        ST_CALC: begin
          r_s   <= {w_sum, r_s[WIDTH-1:1]};
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_carry;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_cout <= w_carry;
            r_sign <= w_sign_calc;
            // Prime the slice for a possible negate pass (+1 of the two's complement).
            r_cnt  <= '0;
            r_c    <= 1'b1;
          end
        end
`ifdef SERIAL_ADD_SUB_NEGATE_EN
        ST_NEG: begin
          r_s   <= {w_sum, r_s[WIDTH-1:1]};
          r_c   <= w_carry;
          r_cnt <= r_cnt + CW'(1);
        end
`endif
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);
  assign S           = r_s;
  assign Cout        = r_cout;
  assign sign        = r_sign;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: directed cases, start-while-busy, mid-op reset, random ops.
// Handshake: start is sampled only while busy=0; results are valid in the single cycle done=1.
module tb_serial_add_sub;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         CTR;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         Cout;
  logic         sign;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .CTR(CTR),
    .busy(busy), .done(done), .S(S), .Cout(Cout), .sign(sign),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation's definition.
  task automatic ref_model(input int a, input int b, input int ctr,
                           output int s, output int co, output int sg, output int lat);
    int m;
    m   = 1 << W;
    lat = W;
    if (ctr == 0) begin
      s  = (a + b) % m;
      co = ((a + b) >= m) ? 1 : 0;
      sg = 0;
    end else begin
      co = (a >= b) ? 1 : 0;
      sg = 1 - co;
      s  = (a - b + m) % m;
`ifdef SERIAL_ADD_SUB_NEGATE_EN
      if (sg == 1) begin
        s   = b - a;
        lat = 2 * W;
      end
`endif
    end
  endtask

  task automatic do_op(input int a, input int b, input int ctr, input string tag);
    int es, eco, esg, elat, cyc;
    bit seen;
    ref_model(a, b, ctr, es, eco, esg, elat);
    @(negedge clk);
    A = W'(a); B = W'(b); CTR = ctr[0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_accept"}, int'(busy), 1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 3 * W + 4) begin
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1'b1;
      else begin
        A = W'($urandom); B = W'($urandom); CTR = 1'($urandom);
      end
    end
    check({tag, "_latency"}, cyc, elat);
    check({tag, "_S"}, int'(S), es);
    check({tag, "_Cout"}, int'(Cout), eco);
    check({tag, "_sign"}, int'(sign), esg);
    check({tag, "_busy_done"}, int'(busy), 1);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_busy_idle"}, int'(busy), 0);
    check({tag, "_S_held"}, int'(S), es);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; CTR = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_S", int'(S), 0);
    check("rst_Cout", int'(Cout), 0);
    check("rst_sign", int'(sign), 0);
    @(negedge clk);
    rst = 1'b0;

    do_op(4'b1111, 4'b0111, 0, "add_f_7");
    do_op(4'b0000, 4'b0001, 1, "sub_neg");
    do_op(4'b0101, 4'b0101, 1, "sub_zero");
    do_op(4'b1001, 4'b0011, 1, "sub_pos");

    // Start while busy: pulses at k+1 and k+4 must be ignored.
    @(negedge clk);
    A = 4'b0011; B = 4'b0001; CTR = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = 4'b1111; B = 4'b1111;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("swb_busy_k1", int'(busy), 1);
    pulses = 0;
    @(posedge clk); #1; if (done) pulses++;
    @(posedge clk); #1; if (done) pulses++;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("swb_done_k4", int'(done), 1);
    check("swb_S", int'(S), 4'b0100);
    check("swb_Cout", int'(Cout), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
      check("swb_busy_after", int'(busy), 0);
    end
    check("swb_extra_pulses", pulses, 0);

    // Start held through DONE: accepted on the first IDLE edge.
    @(negedge clk);
    A = 4'b0101; B = 4'b0110; CTR = 1'b0; start = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check("held_done", int'(done), 1);
    check("held_S1", int'(S), 4'b1011);
    @(posedge clk); #1;
    check("held_idle_busy", int'(busy), 0);
    @(posedge clk); #1;
    check("held_reaccept_busy", int'(busy), 1);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("held_done2_early", int'(done), 0);
    @(posedge clk); #1;
    check("held_done2", int'(done), 1);
    check("held_S2", int'(S), 4'b1011);
    @(posedge clk); #1;

    // Reset mid-operation discards the result immediately.
    @(negedge clk);
    A = 4'b0111; B = 4'b0001; CTR = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_S", int'(S), 0);
    check("mid_rst_Cout", int'(Cout), 0);
    check("mid_rst_sign", int'(sign), 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check("mid_rst_no_activity", pulses, 0);
    do_op(1, 1, 0, "post_rst_add");

    for (int i = 0; i < 24; i++) begin
      int a, b;
      a = $urandom_range(0, (1 << W) - 1);
      b = (i % 6 == 0) ? a : $urandom_range(0, (1 << W) - 1);
      do_op(a, b, $urandom_range(0, 1), $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
